counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Scheduler that drives the counter core's config/action inputs (enable, auto_restart, cap, load, load_val) from a small programmable table of phases, advancing on the core's overflow pulse. Each phase loads a start value, runs to a cap, and repeats a programmed number of times before moving to the next entry. Sits between the counter register block (programming/start/stop source) and the counter core; software queues a cap/period pattern once and it plays back without per-overflow bus traffic.

Parameters:
DEPTH, 4, number of table entries; power of 2, >= 2; AW = $clog2(DEPTH)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
prog_we  input  1  table write strobe
prog_addr  input  AW  table entry index
prog_cap  input  32  entry cap value
prog_load_val  input  32  entry start value
prog_repeat  input  8  extra overflows per entry (0 = run once)
cfg_last_idx  input  AW  index of last active entry, sampled at start
cfg_loop  input  1  1 = wrap to entry 0 after last, 0 = finish; sampled at start
start  input  1  begin sequence (pulse)
stop  input  1  abort sequence (pulse)
overflow  input  1  counter core overflow pulse
enable  output  1  to core
auto_restart  output  1  to core
cap  output  32  to core
load  output  1  to core, one-cycle pulse
load_val  output  32  to core
busy  output  1  state != IDLE
cur_idx  output  AW  entry currently loaded/running
done  output  1  one-cycle pulse on non-loop completion

Behaviour:
- All outputs registered. Reset: every output 0, state IDLE, all table entries 0, captured cfg 0.
- States: IDLE, LOAD, RUN.
- IDLE: enable=0, load=0. start && !stop -> LOAD, idx=0; capture cfg_last_idx, cfg_loop.
- LOAD (exactly 1 cycle): load=1, enable=0, cap/load_val = table[idx] (latched into output regs on entry), rep_left=table[idx].repeat; -> RUN. Overflow in LOAD ignored.
- RUN: enable=1, auto_restart=1, load=0, cap held. On overflow:
  - rep_left != 0: rep_left-1, stay RUN (core restarts itself).
  - rep_left == 0 and idx != last: idx+1 -> LOAD.
  - rep_left == 0, idx == last, loop=1: idx=0 -> LOAD.
  - rep_left == 0, idx == last, loop=0: -> IDLE, done=1 for one cycle, enable=0.
- Latency: start at cycle t -> load=1 at t+1 -> enable=1 at t+2. Overflow at t -> next LOAD at t+1.
- stop: any state -> IDLE next cycle, enable=0, load=0, no done. stop wins over simultaneous overflow or start.
- start while busy: ignored.
- Table writes allowed at any time, 1-cycle write. Output cap/load_val change only at LOAD; a mid-run write to the current entry takes effect on its next LOAD. Write and LOAD read of the same entry in the same cycle: LOAD gets old value.
- cfg_last_idx/cfg_loop changes while busy: no effect until next start.
- cur_idx updates on entry to LOAD; holds last value in IDLE.
- Reset mid-sequence: immediate return to reset state; table cleared.

Decomposition:
- Package counter_seq_pkg: seq_state_t enum {IDLE, LOAD, RUN}; SEQ_CNT_W=32, SEQ_REP_W=8; seq_entry_t struct {cap, load_val, repeat}.
- Sub-module counter_seq_table: DEPTH x seq_entry_t register file, one sync write port, one combinational read port, synchronous reset clear.

Test Plan:
- Program e0={cap=5, lv=1, rep=0}, e1={cap=9, lv=2, rep=1}, last=1, loop=0; start -> load pulse cap=5/lv=1, 1 overflow -> load cap=9/lv=2, 2 overflows -> done pulse, busy=0, enable=0.
- Same table, loop=1 -> after e1's 2nd overflow, LOAD with cur_idx=0, cap=5; runs indefinitely; stop -> enable=0 next cycle, done never asserted.
- stop and overflow in same cycle during RUN with rep_left=0 -> IDLE, no LOAD, no done.
- Rewrite e0.cap=7 while e0 RUN (rep=2) -> cap stays 5 until next LOAD of e0 (loop=1), then 7.
- start while busy, plus start+stop together in IDLE -> no state change, no load pulse.
- Assert reset in RUN at idx=1 -> next cycle all outputs 0, IDLE; restart without programming -> load with cap=0, lv=0.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and phase-table entry layout.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package counter_seq_pkg;

    localparam int SEQ_CNT_W = 32;
    localparam int SEQ_REP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    // One phase of the playback pattern. repeat_cnt counts extra overflows
    // beyond the first, so 0 means the phase runs exactly once.
    typedef struct packed {
        logic [SEQ_CNT_W-1:0] cap;
        logic [SEQ_CNT_W-1:0] load_val;
        logic [SEQ_REP_W-1:0] repeat_cnt;
    } seq_entry_t;

endpackage

// File: rtl/counter_seq_table.sv
// Phase table: DEPTH x seq_entry_t register file, one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write strobe; read is same-cycle.
// Backpressure: none, writes are accepted every cycle.
//
// Ports: clk/reset (sync, active-high, clears all entries); we/waddr/wdata write port;
//        raddr/rdata combinational read port.
module counter_seq_table
    import counter_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  seq_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output seq_entry_t    rdata
);

    seq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reading the array (not the write data) means a same-cycle write and
    // read of one entry returns the old contents.
    assign rdata = mem[raddr];

endmodule

// File: rtl/counter_sequencer.sv
// Plays a programmed table of cap/start-value phases into the counter core, advancing on core overflow.
// Latency: start -> load pulse 1 cycle later -> enable 2 cycles later; overflow -> next load 1 cycle later.
// Backpressure: none; start while busy is dropped, stop aborts from any state and wins over start/overflow.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   prog_we/addr/cap/load_val/repeat   table write port (usable at any time)
//   cfg_last_idx, cfg_loop      sequence shape, captured on start
//   start, stop, overflow       control pulses and core overflow
//   enable, auto_restart, cap, load, load_val   registered drive to the counter core
//   busy, cur_idx, done         status
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_cap,
    input  logic [31:0]   prog_load_val,
    input  logic [7:0]    prog_repeat,
    input  logic [AW-1:0] cfg_last_idx,
    input  logic          cfg_loop,
    input  logic          start,
    input  logic          stop,
    input  logic          overflow,
    output logic          enable,
    output logic          auto_restart,
    output logic [31:0]   cap,
    output logic          load,
    output logic [31:0]   load_val,
    output logic          busy,
    output logic [AW-1:0] cur_idx,
    output logic          done
);

    seq_state_t state, state_n;

    logic [AW-1:0]        idx, idx_n;
    logic [AW-1:0]        last_q, last_n;
    logic                 loop_q, loop_n;
    logic [SEQ_REP_W-1:0] rep_left, rep_n;

    logic [SEQ_CNT_W-1:0] cap_q, cap_n;
    logic [SEQ_CNT_W-1:0] lv_q, lv_n;
    logic                 enable_q, enable_n;
    logic                 auto_q, auto_n;
    logic                 load_q, load_n;
    logic                 done_q, done_n;

    logic                 go_load;
    logic [AW-1:0]        load_idx;
    seq_entry_t           wr_entry;
    seq_entry_t           rd_entry;

    assign wr_entry = '{cap: prog_cap, load_val: prog_load_val, repeat_cnt: prog_repeat};

    // The table is read at the index we are about to enter, so the entry is
    // latched into the output registers on the same edge that enters LOAD.
    counter_seq_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (wr_entry),
        .raddr (load_idx),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        last_n   = last_q;
        loop_n   = loop_q;
        rep_n    = rep_left;
        done_n   = 1'b0;
        go_load  = 1'b0;
        load_idx = idx;

        if (stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        go_load  = 1'b1;
                        load_idx = '0;
                        last_n   = cfg_last_idx;
                        loop_n   = cfg_loop;
                    end
                end
                LOAD: begin
                    // Overflow here belongs to the previous phase's count; ignore it.
                    state_n = RUN;
                end
                RUN: begin
                    if (overflow) begin
                        if (rep_left != '0) begin
                            rep_n = rep_left - 1'b1;
                        end else if (idx != last_q) begin
                            go_load  = 1'b1;
                            load_idx = idx + 1'b1;
                        end else if (loop_q) begin
                            go_load  = 1'b1;
                            load_idx = '0;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (go_load) begin
            state_n = LOAD;
            idx_n   = load_idx;
            rep_n   = rd_entry.repeat_cnt;
        end

        cap_n    = go_load ? rd_entry.cap      : cap_q;
        lv_n     = go_load ? rd_entry.load_val : lv_q;
        load_n   = go_load;
        enable_n = (state_n == RUN);
        auto_n   = (state_n == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            last_q   <= '0;
            loop_q   <= 1'b0;
            rep_left <= '0;
            cap_q    <= '0;
            lv_q     <= '0;
            enable_q <= 1'b0;
            auto_q   <= 1'b0;
            load_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            idx      <= idx_n;
            last_q   <= last_n;
            loop_q   <= loop_n;
            rep_left <= rep_n;
            cap_q    <= cap_n;
            lv_q     <= lv_n;
            enable_q <= enable_n;
            auto_q   <= auto_n;
            load_q   <= load_n;
            done_q   <= done_n;
        end
    end

    assign enable       = enable_q;
    assign auto_restart = auto_q;
    assign cap          = cap_q;
    assign load_val     = lv_q;
    assign load         = load_q;
    assign done         = done_q;
    assign cur_idx      = idx;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [1:0]  prog_addr;
    logic [31:0] prog_cap;
    logic [31:0] prog_load_val;
    logic [7:0]  prog_repeat;
    logic [1:0]  cfg_last_idx;
    logic        cfg_loop;
    logic        start;
    logic        stop;
    logic        overflow;
    logic        enable;
    logic        auto_restart;
    logic [31:0] cap;
    logic        load;
    logic [31:0] load_val;
    logic        busy;
    logic [1:0]  cur_idx;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_sequencer #(.DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_cap      (prog_cap),
        .prog_load_val (prog_load_val),
        .prog_repeat   (prog_repeat),
        .cfg_last_idx  (cfg_last_idx),
        .cfg_loop      (cfg_loop),
        .start         (start),
        .stop          (stop),
        .overflow      (overflow),
        .enable        (enable),
        .auto_restart  (auto_restart),
        .cap           (cap),
        .load          (load),
        .load_val      (load_val),
        .busy          (busy),
        .cur_idx       (cur_idx),
        .done          (done)
    );

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [1:0] a, input logic [31:0] c, input logic [31:0] lv, input logic [7:0] r);
        prog_we = 1'b1; prog_addr = a; prog_cap = c; prog_load_val = lv; prog_repeat = r;
        cyc();
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_ovf();
        overflow = 1'b1;
        cyc();
        overflow = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    // {busy, load, enable, auto_restart, done}
    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc();
        total++;
        if ({busy, load, enable, auto_restart, done} !== 5'b00000) begin
            bad++; $display("FAIL reset_flags got=%b want=%b", {busy, load, enable, auto_restart, done}, 5'b00000);
        end
        total++;
        if ({cap, load_val, cur_idx} !== 66'd0) begin
            bad++; $display("FAIL reset_data got cap=%0d lv=%0d idx=%0d want 0/0/0", cap, load_val, cur_idx);
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_run_once();
        prog(2'd0, 32'd5, 32'd1, 8'd0);
        prog(2'd1, 32'd9, 32'd2, 8'd1);
        cfg_last_idx = 2'd1; cfg_loop = 1'b0;
        pulse_start();
        total++;
        if ({busy, load, enable, done, cap, load_val, cur_idx} !== {4'b1100, 32'd5, 32'd1, 2'd0}) begin
            bad++; $display("FAIL once_load0 got flags=%b cap=%0d lv=%0d idx=%0d want 1100/5/1/0",
                            {busy, load, enable, done}, cap, load_val, cur_idx);
        end
        cyc();
        total++;
        if ({busy, load, enable, auto_restart, done} !== 5'b10110) begin
            bad++; $display("FAIL once_run0 got=%b want=10110", {busy, load, enable, auto_restart, done});
        end
        pulse_ovf();
        total++;
        if ({busy, load, enable, done, cap, load_val, cur_idx} !== {4'b1100, 32'd9, 32'd2, 2'd1}) begin
            bad++; $display("FAIL once_load1 got flags=%b cap=%0d lv=%0d idx=%0d want 1100/9/2/1",
                            {busy, load, enable, done}, cap, load_val, cur_idx);
        end
        cyc();
        pulse_ovf();
        total++;
        if ({busy, load, enable, done} !== 4'b1010) begin
            bad++; $display("FAIL once_repeat got=%b want=1010", {busy, load, enable, done});
        end
        pulse_ovf();
        total++;
        if ({busy, load, enable, auto_restart, done} !== 5'b00001) begin
            bad++; $display("FAIL once_done got=%b want=00001", {busy, load, enable, auto_restart, done});
        end
        cyc();
        total++;
        if ({busy, done, cur_idx} !== 4'b0001) begin
            bad++; $display("FAIL once_done_clear got busy=%b done=%b idx=%0d want 0/0/1", busy, done, cur_idx);
        end
    endtask

    task automatic test_loop();
        logic seen_done;
        cfg_loop = 1'b1;
        pulse_start();
        cyc();
        pulse_ovf();
        cyc();
        pulse_ovf();
        pulse_ovf();
        total++;
        if ({load, cap, load_val, cur_idx} !== {1'b1, 32'd5, 32'd1, 2'd0}) begin
            bad++; $display("FAIL loop_wrap got load=%b cap=%0d lv=%0d idx=%0d want 1/5/1/0", load, cap, load_val, cur_idx);
        end
        cyc();
        pulse_ovf();
        total++;
        if ({load, cap, cur_idx} !== {1'b1, 32'd9, 2'd1}) begin
            bad++; $display("FAIL loop_second got load=%b cap=%0d idx=%0d want 1/9/1", load, cap, cur_idx);
        end
        cyc();
        pulse_stop();
        total++;
        if ({busy, load, enable, done} !== 4'b0000) begin
            bad++; $display("FAIL loop_stop got=%b want=0000", {busy, load, enable, done});
        end
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            seen_done = seen_done | done;
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++; $display("FAIL loop_no_done got=%b want=0", seen_done);
        end
    endtask

    task automatic test_stop_overflow();
        cfg_loop = 1'b0;
        pulse_start();
        cyc();
        stop = 1'b1; overflow = 1'b1;
        cyc();
        stop = 1'b0; overflow = 1'b0;
        total++;
        if ({busy, load, enable, done, cur_idx} !== {4'b0000, 2'd0}) begin
            bad++; $display("FAIL stop_ovf got flags=%b idx=%0d want 0000/0", {busy, load, enable, done}, cur_idx);
        end
        cyc();
        total++;
        if ({busy, load, done} !== 3'b000) begin
            bad++; $display("FAIL stop_ovf_after got=%b want=000", {busy, load, done});
        end
    endtask

    task automatic test_midrun_write();
        prog(2'd0, 32'd5, 32'd1, 8'd2);
        prog(2'd1, 32'd9, 32'd2, 8'd0);
        cfg_last_idx = 2'd1; cfg_loop = 1'b1;
        pulse_start();
        cyc();
        prog(2'd0, 32'd7, 32'd1, 8'd2);
        total++;
        if ({busy, cap} !== {1'b1, 32'd5}) begin
            bad++; $display("FAIL wr_hold got busy=%b cap=%0d want 1/5", busy, cap);
        end
        pulse_ovf();
        pulse_ovf();
        total++;
        if ({load, cap, cur_idx} !== {1'b0, 32'd5, 2'd0}) begin
            bad++; $display("FAIL wr_repeat got load=%b cap=%0d idx=%0d want 0/5/0", load, cap, cur_idx);
        end
        pulse_ovf();
        cyc();
        pulse_ovf();
        total++;
        if ({load, cap, cur_idx} !== {1'b1, 32'd7, 2'd0}) begin
            bad++; $display("FAIL wr_reload got load=%b cap=%0d idx=%0d want 1/7/0", load, cap, cur_idx);
        end
        cyc();
        pulse_ovf(); pulse_ovf(); pulse_ovf();
        cyc();
        // Write of e0 on the same edge as its LOAD: LOAD must see the old cap.
        prog_we = 1'b1; prog_addr = 2'd0; prog_cap = 32'd11; prog_load_val = 32'd1; prog_repeat = 8'd2;
        overflow = 1'b1;
        cyc();
        prog_we = 1'b0; overflow = 1'b0;
        total++;
        if ({load, cap, cur_idx} !== {1'b1, 32'd7, 2'd0}) begin
            bad++; $display("FAIL wr_collide got load=%b cap=%0d idx=%0d want 1/7/0", load, cap, cur_idx);
        end
        cyc();
        pulse_stop();
    endtask

    task automatic test_start_busy();
        prog(2'd0, 32'd5, 32'd1, 8'd1);
        prog(2'd1, 32'd9, 32'd2, 8'd0);
        cfg_last_idx = 2'd1; cfg_loop = 1'b0;
        pulse_start();
        // overflow while in LOAD must not consume a repeat
        pulse_ovf();
        pulse_ovf();
        total++;
        if ({busy, load, enable, cur_idx} !== {3'b101, 2'd0}) begin
            bad++; $display("FAIL ovf_in_load got flags=%b idx=%0d want 101/0", {busy, load, enable}, cur_idx);
        end
        pulse_start();
        total++;
        if ({busy, load, enable, cur_idx} !== {3'b101, 2'd0}) begin
            bad++; $display("FAIL start_busy got flags=%b idx=%0d want 101/0", {busy, load, enable}, cur_idx);
        end
        pulse_stop();
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        total++;
        if ({busy, load, enable} !== 3'b000) begin
            bad++; $display("FAIL start_stop_idle got=%b want=000", {busy, load, enable});
        end
        cyc();
        total++;
        if ({busy, load} !== 2'b00) begin
            bad++; $display("FAIL start_stop_after got=%b want=00", {busy, load});
        end
    endtask

    task automatic test_reset_midrun();
        prog(2'd0, 32'd5, 32'd1, 8'd0);
        prog(2'd1, 32'd9, 32'd2, 8'd3);
        cfg_last_idx = 2'd1; cfg_loop = 1'b0;
        pulse_start();
        cyc();
        pulse_ovf();
        cyc();
        total++;
        if ({busy, enable, cur_idx} !== {2'b11, 2'd1}) begin
            bad++; $display("FAIL pre_reset got busy=%b en=%b idx=%0d want 1/1/1", busy, enable, cur_idx);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        total++;
        if ({busy, load, enable, auto_restart, done, cap, load_val, cur_idx} !== 71'd0) begin
            bad++; $display("FAIL midrun_reset got flags=%b cap=%0d lv=%0d idx=%0d want all 0",
                            {busy, load, enable, auto_restart, done}, cap, load_val, cur_idx);
        end
        pulse_start();
        total++;
        if ({load, cap, load_val, cur_idx} !== {1'b1, 32'd0, 32'd0, 2'd0}) begin
            bad++; $display("FAIL cleared_table got load=%b cap=%0d lv=%0d idx=%0d want 1/0/0/0", load, cap, load_val, cur_idx);
        end
        pulse_stop();
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_cap = '0; prog_load_val = '0;
        prog_repeat = '0; cfg_last_idx = '0; cfg_loop = 1'b0; start = 1'b0; stop = 1'b0; overflow = 1'b0;
        test_reset();
        test_run_once();
        test_loop();
        test_stop_overflow();
        test_midrun_write();
        test_start_busy();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
